// File: rtl/mux6_pkg.sv
// Shared lane/op types for the six-lane result collector.
// The op encoding matches the one-to-six demux: values 0..5 name the lane.
package mux6_pkg;

  localparam int LANES = 6;
  localparam int OP_W  = 3;

  typedef logic [OP_W-1:0]  op_t;
  typedef logic [LANES-1:0] lane_mask_t;

  // Lane index increment that wraps from the last lane back to lane 0,
  // so the codes 6 and 7 are never produced.
  function automatic op_t next_lane(input op_t lane);
    return (lane >= op_t'(LANES - 1)) ? op_t'(0) : op_t'(lane + op_t'(1));
  endfunction

endpackage

// File: rtl/rr_arbiter6.sv
// Six-way arbiter for the result collector.
// Default build: round robin starting after the last granted lane. The pointer
// resets to lane 5, so lane 0 is the first lane to win.
// With MUX6_FIXED_PRIORITY_EN defined: fixed priority, lane 0 highest. There
// is no pointer in that build, so the clock and reset ports are not present.
// The grant is combinational and one-hot. It is forced to zero when enable is low.
module rr_arbiter6
  import mux6_pkg::*;
(
`ifndef MUX6_FIXED_PRIORITY_EN
  input  logic       clock,
  input  logic       reset_n,
`endif
  input  lane_mask_t req,
  input  logic       enable,
  output lane_mask_t grant,
  output op_t        idx
);

  lane_mask_t pick;
  op_t        pick_idx;
  logic       found;

`ifdef MUX6_FIXED_PRIORITY_EN
  // Lowest-numbered requesting lane wins.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (!found && req[i]) begin
        found    = 1'b1;
        pick[i]  = 1'b1;
        pick_idx = op_t'(i);
      end
    end
  end
`else
  op_t last;
  op_t cand;

  // Visit lanes in the order last+1, last+2, ... (mod 6). The first requester wins.
  // The inner compare loop avoids indexing req with a 3-bit value that could
  // address lanes 6 or 7.
  always_comb begin
    pick     = '0;
    pick_idx = '0;
    found    = 1'b0;
    cand     = next_lane(last);
    for (int k = 0; k < LANES; k++) begin
      for (int i = 0; i < LANES; i++) begin
        if (!found && (cand == op_t'(i)) && req[i]) begin
          found    = 1'b1;
          pick[i]  = 1'b1;
          pick_idx = cand;
        end
      end
      cand = next_lane(cand);
    end
  end

  // The pointer moves only on an actual grant. A stalled output keeps it in place.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last <= op_t'(LANES - 1);
    end else if (enable && found) begin
      last <= pick_idx;
    end
  end
`endif

  assign grant = enable ? pick : '0;
  assign idx   = pick_idx;

endmodule

// File: rtl/mux_six_to_one_collector.sv
// Merges six result lanes into one registered valid/ready stream.
// out_op reports the source lane using the demux op encoding (0..5).
// Arbitration lives in rr_arbiter6. Defining MUX6_FIXED_PRIORITY_EN switches
// it from round robin to fixed priority.
module mux_six_to_one_collector
  import mux6_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [LANES-1:0]       in_valid,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES-1:0]       in_ready,
  output logic                   out_valid,
  output logic [WIDTH-1:0]       out_data,
  output logic [OP_W-1:0]        out_op,
  input  logic                   out_ready
);

  logic             load;
  logic             arb_en;
  lane_mask_t       grant;
  op_t              grant_idx;
  logic [WIDTH-1:0] grant_data;

  // The register can accept a word when it is empty or being drained.
  // Reset also gates the arbiter, so in_ready stays low while reset_n is low.
  assign load   = ~out_valid | out_ready;
  assign arb_en = load & reset_n;

  rr_arbiter6 u_arb (
`ifndef MUX6_FIXED_PRIORITY_EN
    .clock   (clock),
    .reset_n (reset_n),
`endif
    .req     (in_valid),
    .enable  (arb_en),
    .grant   (grant),
    .idx     (grant_idx)
  );

  assign in_ready = grant;

  // One-hot data select, driven from the grant vector.
  always_comb begin
    grant_data = '0;
    for (int i = 0; i < LANES; i++) begin
      if (grant[i]) grant_data = in_data[i*WIDTH +: WIDTH];
    end
  end

  // Output register: load on grant, go empty on drain without a new grant,
  // otherwise hold. Data and op keep their last values when the register goes empty.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_op    <= '0;
    end else if (load) begin
      if (|grant) begin
        out_valid <= 1'b1;
        out_data  <= grant_data;
        out_op    <= grant_idx;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
